// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   Execute-side operand select plus the EX/MEM pipeline register.
//   The forwarding unit supplies the operand selects and the load-use stall;
//   this block picks the ALU operands, captures the EX result/control into
//   the MEM stage, injects bubbles on stall or flush, and keeps a saturating
//   count of stall cycles for performance monitoring.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   stall, flush     load-use stall / branch-taken flush of the EX instruction
//   ALUsel1/2        operand selects: 0 rf, 1 MEM result, 2 WB result, 3 rf
//   rf_data1/2       EX operands from the ID/EX register
//   wb_fwd_data      value being written back in WB
//   alu_result       ALU output for the current EX instruction
//   ex_opcode/dst/wb EX instruction control
//   alu_op1/2        selected ALU operands (combinational)
//   mem_*            registered MEM-stage instruction state
//   stall_count      saturating count of stall cycles
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        ALUsel1,
    input  logic [1:0]        ALUsel2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic              ex_wb,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OP_W-1:0]   mem_opcode,
    output logic [REG_W-1:0]  mem_dst,
    output logic              mem_wb,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_MEM = 2'd1,
        SEL_WB  = 2'd2,
        SEL_RF3 = 2'd3
    } fwd_sel_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Forwarding mux: MEM forwarding taps this stage's own result register.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] wb_val
    );
        case (fwd_sel_e'(sel))
            SEL_MEM: return mem_val;
            SEL_WB:  return wb_val;
            default: return rf_val;
        endcase
    endfunction

    // NOTE: every always_comb output gets a value on every path (here via the
    // function's default arm), otherwise synthesis infers a latch.
    always_comb begin
        alu_op1 = fwd_pick(ALUsel1, rf_data1, mem_alu_result, wb_fwd_data);
        alu_op2 = fwd_pick(ALUsel2, rf_data2, mem_alu_result, wb_fwd_data);
    end

    logic bubble;
    assign bubble = flush | stall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_opcode     <= '0;
            mem_dst        <= '0;
            mem_wb         <= 1'b0;
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
        end else if (bubble) begin
            // Flush outranks stall, but both insert the same bubble; the
            // instruction already in MEM still moves on to WB.
            mem_opcode     <= '0;
            mem_dst        <= '0;
            mem_wb         <= 1'b0;
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
        end else begin
            mem_opcode     <= ex_opcode;
            mem_dst        <= ex_dst;
            mem_wb         <= ex_wb;
            mem_valid      <= (ex_opcode != '0);
            mem_alu_result <= alu_result;
            // Captured for every opcode; consumers only look at it for stores.
            mem_store_data <= alu_op2;
        end
    end

    // Counts only true load-use stalls: a flush on the same edge means the
    // stalled instruction is being discarded anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !flush && stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Table-driven bench for ex_mem_stage (CNT_W reduced to 4 so saturation
//   is reachable). Each row gives inputs, the combinational operands expected
//   before the edge, and the MEM-stage state expected after it; the latter
//   goes through a scoreboard queue. Hand-written sequences cover reset,
//   reset during stall and counter saturation.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic [1:0]        ALUsel1;
    logic [1:0]        ALUsel2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] wb_fwd_data;
    logic [DATA_W-1:0] alu_result;
    logic [OP_W-1:0]   ex_opcode;
    logic [REG_W-1:0]  ex_dst;
    logic              ex_wb;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [OP_W-1:0]   mem_opcode;
    logic [REG_W-1:0]  mem_dst;
    logic              mem_wb;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [CNT_W-1:0]  stall_count;

    ex_mem_stage #(
        .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ALUsel1(ALUsel1), .ALUsel2(ALUsel2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_fwd_data(wb_fwd_data), .alu_result(alu_result),
        .ex_opcode(ex_opcode), .ex_dst(ex_dst), .ex_wb(ex_wb),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .mem_opcode(mem_opcode), .mem_dst(mem_dst), .mem_wb(mem_wb),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              stall;
        logic              flush;
        logic [1:0]        sel1;
        logic [1:0]        sel2;
        logic [DATA_W-1:0] rf1;
        logic [DATA_W-1:0] rf2;
        logic [DATA_W-1:0] wbd;
        logic [DATA_W-1:0] alu;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  dst;
        logic              exwb;
        logic [DATA_W-1:0] e_op1;
        logic [DATA_W-1:0] e_op2;
        logic [OP_W-1:0]   e_mop;
        logic [REG_W-1:0]  e_mdst;
        logic              e_mwb;
        logic              e_mvalid;
        logic [DATA_W-1:0] e_mres;
        logic [DATA_W-1:0] e_msd;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    vec_t sb_q [$];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string tag, input vec_t e);
        check({tag, " mem_opcode"},     32'(mem_opcode),     32'(e.e_mop));
        check({tag, " mem_dst"},        32'(mem_dst),        32'(e.e_mdst));
        check({tag, " mem_wb"},         32'(mem_wb),         32'(e.e_mwb));
        check({tag, " mem_valid"},      32'(mem_valid),      32'(e.e_mvalid));
        check({tag, " mem_alu_result"}, 32'(mem_alu_result), 32'(e.e_mres));
        check({tag, " mem_store_data"}, 32'(mem_store_data), 32'(e.e_msd));
        check({tag, " stall_count"},    32'(stall_count),    32'(e.e_cnt));
    endtask

    task automatic drive(input vec_t v);
        stall       = v.stall;
        flush       = v.flush;
        ALUsel1     = v.sel1;
        ALUsel2     = v.sel2;
        rf_data1    = v.rf1;
        rf_data2    = v.rf2;
        wb_fwd_data = v.wbd;
        alu_result  = v.alu;
        ex_opcode   = v.op;
        ex_dst      = v.dst;
        ex_wb       = v.exwb;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        //           stl flu s1 s2 rf1       rf2       wbd       alu       op  dst ewb  op1       op2       mop mdst mwb mval mres      msd       cnt
        vecs[0] = '{1'b0,1'b0,2'd0,2'd0,16'h0011,16'h0022,16'h0F0F,16'h0033,4'd1, 3'd2,1'b1,16'h0011,16'h0022,4'd1, 3'd2,1'b1,1'b1,16'h0033,16'h0022,4'd0};
        vecs[1] = '{1'b0,1'b0,2'd1,2'd2,16'h0001,16'h0002,16'h0F0F,16'h1234,4'd11,3'd0,1'b0,16'h0033,16'h0F0F,4'd11,3'd0,1'b0,1'b1,16'h1234,16'h0F0F,4'd0};
        vecs[2] = '{1'b0,1'b0,2'd1,2'd3,16'h0001,16'h0005,16'hBEEF,16'h4321,4'd10,3'd3,1'b1,16'h1234,16'h0005,4'd10,3'd3,1'b1,1'b1,16'h4321,16'h0005,4'd0};
        vecs[3] = '{1'b1,1'b0,2'd3,2'd0,16'h0001,16'h0007,16'hBEEF,16'h7777,4'd3, 3'd4,1'b1,16'h0001,16'h0007,4'd0, 3'd0,1'b0,1'b0,16'h0000,16'h0000,4'd1};
        vecs[4] = '{1'b0,1'b0,2'd2,2'd1,16'h1111,16'h2222,16'h00AA,16'h00AB,4'd3, 3'd4,1'b1,16'h00AA,16'h0000,4'd3, 3'd4,1'b1,1'b1,16'h00AB,16'h0000,4'd1};
        vecs[5] = '{1'b1,1'b1,2'd1,2'd2,16'h0101,16'h0202,16'hBEEF,16'h9999,4'd11,3'd1,1'b0,16'h00AB,16'hBEEF,4'd0, 3'd0,1'b0,1'b0,16'h0000,16'h0000,4'd1};
        vecs[6] = '{1'b0,1'b1,2'd0,2'd0,16'h0303,16'h0404,16'hBEEF,16'h0505,4'd1, 3'd5,1'b1,16'h0303,16'h0404,4'd0, 3'd0,1'b0,1'b0,16'h0000,16'h0000,4'd1};
        vecs[7] = '{1'b0,1'b0,2'd0,2'd2,16'h0010,16'h0020,16'hBEEF,16'h0030,4'd11,3'd0,1'b0,16'h0010,16'hBEEF,4'd11,3'd0,1'b0,1'b1,16'h0030,16'hBEEF,4'd1};
        vecs[8] = '{1'b0,1'b0,2'd1,2'd1,16'h0000,16'h0000,16'hBEEF,16'h00FF,4'd0, 3'd0,1'b0,16'h0030,16'h0030,4'd0, 3'd0,1'b0,1'b0,16'h00FF,16'h0030,4'd1};
        vecs[9] = '{1'b0,1'b0,2'd2,2'd3,16'h0000,16'hFFFF,16'h8000,16'hFFFE,4'd8, 3'd7,1'b1,16'h8000,16'hFFFF,4'd8, 3'd7,1'b1,1'b1,16'hFFFE,16'hFFFF,4'd1};

        // Power-on reset.
        v = '{default: '0};
        drive(v);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("por mem_valid",   32'(mem_valid),      32'd0);
        check("por mem_result",  32'(mem_alu_result), 32'd0);
        check("por stall_count", 32'(stall_count),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: combinational operands checked before the edge, MEM-stage
        // state pushed to the scoreboard and compared after it.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sb_q.push_back(vecs[i]);
            #1;
            check($sformatf("v%0d alu_op1", i), 32'(alu_op1), 32'(vecs[i].e_op1));
            check($sformatf("v%0d alu_op2", i), 32'(alu_op2), 32'(vecs[i].e_op2));
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_mem($sformatf("v%0d", i), e);
            end
        end

        // Async reset between edges, with a stall in progress.
        @(negedge clk);
        v = '{default: '0};
        v.op = 4'd1; v.alu = 16'h5A5A; v.dst = 3'd6; v.exwb = 1'b1;
        drive(v);
        @(posedge clk); #1;
        check("pre-rst mem_alu_result", 32'(mem_alu_result), 32'h5A5A);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk); #1;
        check("pre-rst stall_count", 32'(stall_count), 32'd2);
        @(negedge clk);
        ALUsel1 = 2'd1;
        rst = 1'b1;
        #1;
        check("rst mem_alu_result", 32'(mem_alu_result), 32'd0);
        check("rst mem_valid",      32'(mem_valid),      32'd0);
        check("rst mem_opcode",     32'(mem_opcode),     32'd0);
        check("rst stall_count",    32'(stall_count),    32'd0);
        check("rst alu_op1 fwd",    32'(alu_op1),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{default: '0};
        v.op = 4'd2; v.alu = 16'h0042; v.rf2 = 16'h0009; v.dst = 3'd1; v.exwb = 1'b1;
        drive(v);
        @(posedge clk); #1;
        check("post-rst mem_opcode",     32'(mem_opcode),     32'd2);
        check("post-rst mem_valid",      32'(mem_valid),      32'd1);
        check("post-rst mem_alu_result", 32'(mem_alu_result), 32'h0042);
        check("post-rst mem_store_data", 32'(mem_store_data), 32'h0009);
        check("post-rst stall_count",    32'(stall_count),    32'd0);

        // Saturation: 20 consecutive stalls on a 4-bit counter.
        @(negedge clk);
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 14) check("sat count@14", 32'(stall_count), 32'd14);
            if (i == 15) check("sat count@15", 32'(stall_count), 32'd15);
        end
        check("sat count@20", 32'(stall_count), 32'd15);
        check("sat mem_valid", 32'(mem_valid),   32'd0);
        @(negedge clk);
        stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
